// File: rtl/bird_physics.sv
// bird_physics -- vertical-motion engine for the player bird.
//
// Tracks the bird height and signed velocity. Both advance once per frame
// tick, using gravity, a flap impulse and a terminal fall speed. A
// three-state life cycle (IDLE, FLYING, DEAD) gates the physics.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   tick      in   one-cycle frame strobe; physics advances only on it
//   flap      in   debounced button level; a rising edge requests an impulse
//   collision in   pipe-hit indication; kills the bird while FLYING
//   height    out  current height (unsigned, HEIGHT_W bits)
//   velocity  out  current velocity (two's complement, VEL_W bits)
//   state     out  00 IDLE, 01 FLYING, 10 DEAD
//   dead      out  high while state is DEAD
//
// Optional feature macro: BIRD_PHYSICS_CEILING_KILL_EN
//   When defined, reaching the ceiling kills the bird, just like a floor hit.
//   When undefined (the default), the ceiling only clamps the height.

module bird_physics #(
   parameter int HEIGHT_W     = 9,
   parameter int VEL_W        = 6,
   parameter int START_HEIGHT = 240,
   parameter int MIN_HEIGHT   = 0,
   parameter int MAX_HEIGHT   = 500,
   parameter int FLAP_VEL     = 6,
   parameter int GRAVITY      = 1,
   parameter int MAX_FALL     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick,
   input  logic                       flap,
   input  logic                       collision,
   output logic [HEIGHT_W-1:0]        height,
   output logic signed [VEL_W-1:0]    velocity,
   output logic [1:0]                 state,
   output logic                       dead
);

   // One extra velocity bit absorbs v - GRAVITY before saturation.
   // Two extra height bits (sign + carry) make h + v' wrap-free.
   localparam int VW = VEL_W + 1;
   localparam int HW = HEIGHT_W + 2;

   localparam logic signed [VW-1:0]    GRAV     = VW'(GRAVITY);
   localparam logic signed [VW-1:0]    FALL_LIM = VW'(-MAX_FALL);
   localparam logic signed [VEL_W-1:0] FLAP_V   = VEL_W'(FLAP_VEL);
   localparam logic signed [HW-1:0]    MAX_H_S  = HW'(MAX_HEIGHT);
   localparam logic signed [HW-1:0]    MIN_H_S  = HW'(MIN_HEIGHT);
   localparam logic [HEIGHT_W-1:0]     MAX_H    = HEIGHT_W'(MAX_HEIGHT);
   localparam logic [HEIGHT_W-1:0]     MIN_H    = HEIGHT_W'(MIN_HEIGHT);
   localparam logic [HEIGHT_W-1:0]     START_H  = HEIGHT_W'(START_HEIGHT);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FLYING = 2'b01,
      DEAD   = 2'b10
   } state_t;

   // Gravity step with saturation at the terminal fall speed.
   function automatic logic signed [VEL_W-1:0] fall_sat(
      input logic signed [VEL_W-1:0] v
   );
      logic signed [VW-1:0] dec;
      dec = $signed({v[VEL_W-1], v}) - GRAV;
      if (dec < FALL_LIM)
         return FALL_LIM[VEL_W-1:0];
      return dec[VEL_W-1:0];
   endfunction

   // Sign-extended height + velocity in the wide signed domain.
   function automatic logic signed [HW-1:0] height_add(
      input logic [HEIGHT_W-1:0]     h,
      input logic signed [VEL_W-1:0] v
   );
      return $signed({2'b00, h}) + $signed({{(HW-VEL_W){v[VEL_W-1]}}, v});
   endfunction

   state_t                     st, st_nxt;
   logic                       flap_p1;
   logic                       flap_rise;
   logic                       flap_pend, pend_nxt;
   logic [HEIGHT_W-1:0]        h_nxt;
   logic signed [VEL_W-1:0]    v_nxt;
   logic signed [VEL_W-1:0]    v_cand;
   logic signed [HW-1:0]       h_sum;

   // ---- stage p1: registered copy of the button for edge detection ----
   // Left out of reset on purpose: a button held through reset must not
   // look like a fresh press afterwards.
   always_ff @(posedge clk) begin
      flap_p1 <= flap;
   end

   assign flap_rise = flap & ~flap_p1;

   // A press arriving in the same cycle as the tick counts for that tick.
   assign v_cand = (flap_pend | flap_rise) ? FLAP_V : fall_sat(velocity);
   assign h_sum  = height_add(height, v_cand);

   always_comb begin
      st_nxt   = st;
      h_nxt    = height;
      v_nxt    = velocity;
      pend_nxt = flap_pend;
      case (st)
         IDLE: begin
            h_nxt = START_H;
            v_nxt = '0;
            if (flap_rise) begin
               st_nxt   = FLYING;
               pend_nxt = 1'b1;
            end
         end
         FLYING: begin
            // Collision freezes the bird and wins over a simultaneous tick.
            if (collision) begin
               st_nxt = DEAD;
            end else if (tick) begin
               pend_nxt = 1'b0;
               if (h_sum >= MAX_H_S) begin
                  h_nxt = MAX_H;
                  v_nxt = '0;
`ifdef BIRD_PHYSICS_CEILING_KILL_EN
                  st_nxt = DEAD;
`else
                  st_nxt = FLYING;
`endif
               end else if (h_sum <= MIN_H_S) begin
                  h_nxt  = MIN_H;
                  v_nxt  = '0;
                  st_nxt = DEAD;
               end else begin
                  h_nxt = h_sum[HEIGHT_W-1:0];
                  v_nxt = v_cand;
               end
            end else if (flap_rise) begin
               pend_nxt = 1'b1;
            end
         end
         DEAD: begin
            pend_nxt = 1'b0;
         end
         default: begin
            st_nxt   = IDLE;
            h_nxt    = START_H;
            v_nxt    = '0;
            pend_nxt = 1'b0;
         end
      endcase
   end

   // ---- stage p1: architectural state ----
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= IDLE;
         flap_pend <= 1'b0;
         height    <= START_H;
         velocity  <= '0;
         dead      <= 1'b0;
      end else begin
         st        <= st_nxt;
         flap_pend <= pend_nxt;
         height    <= h_nxt;
         velocity  <= v_nxt;
         dead      <= (st_nxt == DEAD);
      end
   end

   assign state = st;

endmodule
